fcore_result_collector: RTL and testbench

- Downstream neighbour of the fCore execution units (logic unit, ALU, FP unit). Merges their result streams into the single register-file write port.
- Execution units drive results without honouring backpressure. The block therefore buffers each source in a small FIFO.
- It arbitrates round-robin onto one registered AXI-stream writeback port.
- `user` carries the destination register address end to end.

---
 rtl/fcore_isa_pkg.sv | 10 +
 rtl/fcore_result_collector_fifo.sv | 47 ++++
 rtl/fcore_result_collector.sv | 118 +++++++++++
 tb/tb_fcore_result_collector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fcore_isa_pkg.sv
// Shared fCore constants and the result entry carried from execution units to the register file.
package fcore_isa;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } result_entry_t;
endpackage

// File: rtl/fcore_result_collector_fifo.sv
// Per-source result FIFO: accepts a push while full only if the head is popped in the same cycle.
module fcore_result_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign push_ok = push_i && (!full_o || pop_i);
    assign drop_o  = push_i && full_o && !pop_i;
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d = (pop_i && !empty_o) ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
    end
endmodule

// File: rtl/fcore_result_collector.sv
// Merges execution-unit result streams through per-source FIFOs into one registered writeback port.
module fcore_result_collector
    import fcore_isa::*;
#(
    parameter int N_SOURCES  = 3,
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clock_i,
    input  logic                                  reset_ni,
    input  logic [N_SOURCES-1:0]                  results_in_valid_i,
    output logic [N_SOURCES-1:0]                  results_in_ready_o,
    input  logic [N_SOURCES-1:0][DATA_WIDTH-1:0]  results_in_data_i,
    input  logic [N_SOURCES-1:0][ADDR_WIDTH-1:0]  results_in_user_i,
    output logic                                  writeback_valid_o,
    input  logic                                  writeback_ready_i,
    output logic [DATA_WIDTH-1:0]                 writeback_data_o,
    output logic [ADDR_WIDTH-1:0]                 writeback_user_o,
    output logic [N_SOURCES-1:0]                  overflow_o,
    output logic                                  busy_o
);
    localparam int RR_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
    localparam int EW   = DATA_WIDTH + ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    entry_t [N_SOURCES-1:0] din, head;
    logic   [N_SOURCES-1:0] empty, full, drop, pop;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] user_q, user_d;
    logic [RR_W-1:0]       rr_q, rr_d, gnt_idx;
    logic [N_SOURCES-1:0]  ovf_q;
    logic                  gnt_vld, load_en;
    int                    idx;

    for (genvar g = 0; g < N_SOURCES; g++) begin : g_src
        assign din[g] = '{data: results_in_data_i[g], addr: results_in_user_i[g]};

        fcore_result_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clock_i),
            .rst_ni  (reset_ni),
            .push_i  (results_in_valid_i[g]),
            .din_i   (din[g]),
            .pop_i   (pop[g]),
            .dout_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .drop_o  (drop[g])
        );
    end

    assign load_en = !valid_q || writeback_ready_i;

    // Round-robin search starting at rr_q, first non-empty source wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < N_SOURCES; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_SOURCES) idx = idx - N_SOURCES;
            if (!gnt_vld && !empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = RR_W'(idx);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        rr_d    = rr_q;
        pop     = '0;
        if (load_en) begin
            if (gnt_vld) begin
                pop[gnt_idx] = 1'b1;
                valid_d      = 1'b1;
                data_d       = head[gnt_idx].data;
                user_d       = head[gnt_idx].addr;
                rr_d         = (gnt_idx == RR_W'(N_SOURCES - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                valid_d = 1'b0;
                data_d  = '0;
                user_d  = '0;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            rr_q    <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_q | drop;
        end
    end

    assign results_in_ready_o = ~full;
    assign writeback_valid_o  = valid_q;
    assign writeback_data_o   = data_q;
    assign writeback_user_o   = user_q;
    assign overflow_o         = ovf_q;
    assign busy_o             = (|(~empty)) || valid_q;
endmodule

// File: tb/tb_fcore_result_collector.sv
// Directed scoreboard bench for the result collector: stimulus queues expected writebacks, a monitor checks them.
module tb_fcore_result_collector;
    import fcore_isa::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0]            in_valid = '0;
    logic [N-1:0]            in_ready;
    logic [N-1:0][DW-1:0]    in_data = '0;
    logic [N-1:0][AW-1:0]    in_user = '0;
    logic                    wb_valid;
    logic                    wb_ready = 1'b1;
    logic [DW-1:0]           wb_data;
    logic [AW-1:0]           wb_user;
    logic [N-1:0]            overflow;
    logic                    busy;

    result_entry_t exp_q[$];
    result_entry_t mon_e;
    int checks = 0;
    int errors = 0;

    fcore_result_collector #(.N_SOURCES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clock_i            (clk),
        .reset_ni           (rst_n),
        .results_in_valid_i (in_valid),
        .results_in_ready_o (in_ready),
        .results_in_data_i  (in_data),
        .results_in_user_i  (in_user),
        .writeback_valid_o  (wb_valid),
        .writeback_ready_i  (wb_ready),
        .writeback_data_o   (wb_data),
        .writeback_user_o   (wb_user),
        .overflow_o         (overflow),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake completes at the next posedge; inputs only change just after posedges.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got data %0h user %0h expected nothing", wb_data, wb_user);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_data", {32'h0, wb_data}, {32'h0, mon_e.data});
                chk("wb_user", {56'h0, wb_user}, {56'h0, mon_e.addr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [DW-1:0] d, input logic [AW-1:0] u);
        result_entry_t e;
        e.data = d;
        e.addr = u;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input int s, input logic [DW-1:0] d, input logic [AW-1:0] u);
        in_valid[s] = 1'b1;
        in_data[s]  = d;
        in_user[s]  = u;
    endtask

    task automatic clr_in();
        in_valid = '0;
        in_data  = '0;
        in_user  = '0;
    endtask

    task automatic do_reset();
        clr_in();
        wb_ready = 1'b1;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2;
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_user", 64'(wb_user), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'h7);
        tick();
        rst_n = 1'b1;
        tick();

        // Single result: visible on writeback after the second edge, for one cycle.
        set_in(0, 32'h0000_00F0, 8'h12);
        sb_push(32'h0000_00F0, 8'h12);
        tick();
        clr_in();
        chk("t1_latency_valid", 64'(wb_valid), 64'd0);
        chk("t1_busy_buffered", 64'(busy), 64'd1);
        tick();
        chk("t1_valid", 64'(wb_valid), 64'd1);
        chk("t1_data", 64'(wb_data), 64'hF0);
        tick();
        chk("t1_valid_drop", 64'(wb_valid), 64'd0);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // Two simultaneous bursts from all sources: strict 0,1,2 rotation.
        do_reset();
        set_in(0, 32'hA, 8'd1); set_in(1, 32'hB, 8'd2); set_in(2, 32'hC, 8'd3);
        tick();
        set_in(0, 32'h1A, 8'd4); set_in(1, 32'h1B, 8'd5); set_in(2, 32'h1C, 8'd6);
        sb_push(32'hA, 8'd1);  sb_push(32'hB, 8'd2);  sb_push(32'hC, 8'd3);
        sb_push(32'h1A, 8'd4); sb_push(32'h1B, 8'd5); sb_push(32'h1C, 8'd6);
        tick();
        clr_in();
        repeat (7) tick();
        chk("t2_busy_idle", 64'(busy), 64'd0);

        // Backpressure: output frozen while ready is low.
        do_reset();
        wb_ready = 1'b0;
        set_in(0, 32'hDEAD, 8'd5);
        sb_push(32'hDEAD, 8'd5);
        tick();
        set_in(0, 32'hBEEF, 8'd6);
        sb_push(32'hBEEF, 8'd6);
        tick();
        clr_in();
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_valid", 64'(wb_valid), 64'd1);
            chk("t3_stall_data", 64'(wb_data), 64'hDEAD);
            chk("t3_stall_user", 64'(wb_user), 64'd5);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("t3_next_data", 64'(wb_data), 64'hBEEF);
        chk("t3_next_valid", 64'(wb_valid), 64'd1);
        tick();
        chk("t3_done_valid", 64'(wb_valid), 64'd0);

        // Overflow: first value moves into the idle output register, four fill the FIFO, sixth is dropped.
        do_reset();
        wb_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            set_in(1, DW'(v), AW'(8'h20 + v));
            if (v <= 5) sb_push(DW'(v), AW'(8'h20 + v));
            tick();
        end
        clr_in();
        chk("t4_overflow", 64'(overflow), 64'h2);
        chk("t4_in_ready_full", 64'(in_ready), 64'h5);
        chk("t4_head_data", 64'(wb_data), 64'd1);
        wb_ready = 1'b1;
        repeat (7) tick();
        chk("t4_overflow_sticky", 64'(overflow), 64'h2);
        chk("t4_busy_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-stream discards everything, including the sticky flag.
        wb_ready = 1'b0;
        set_in(0, 32'h71, 8'h1); set_in(1, 32'h72, 8'h2); set_in(2, 32'h73, 8'h3);
        tick();
        clr_in();
        set_in(0, 32'h74, 8'h4);
        tick();
        clr_in();
        chk("t6_pre_valid", 64'(wb_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(wb_valid), 64'd0);
        chk("t6_rst_data", 64'(wb_data), 64'd0);
        chk("t6_rst_user", 64'(wb_user), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        tick();
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        repeat (5) tick();
        chk("t6_no_stale_valid", 64'(wb_valid), 64'd0);
        chk("t6_no_stale_busy", 64'(busy), 64'd0);

        // Full FIFO accepts a push in the same cycle its head is popped.
        do_reset();
        wb_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            set_in(0, DW'(32'h10 + v), AW'(8'h30 + v));
            sb_push(DW'(32'h10 + v), AW'(8'h30 + v));
            tick();
        end
        clr_in();
        chk("t5_in_ready_full", 64'(in_ready), 64'h6);
        wb_ready = 1'b1;
        set_in(0, 32'h15, 8'h35);
        sb_push(32'h15, 8'h35);
        tick();
        clr_in();
        chk("t5_no_overflow", 64'(overflow), 64'd0);
        chk("t5_still_full", 64'(in_ready), 64'h6);
        chk("t5_data_after_pop", 64'(wb_data), 64'h11);
        repeat (8) tick();
        chk("t5_busy_idle", 64'(busy), 64'd0);
        chk("t5_overflow_final", 64'(overflow), 64'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
